uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 8: number of data bits per frame.
REQ-002 Parameter PRESCALE_WIDTH, default 6: width of the Prescale input.
REQ-003 UART_RX_CLK  input  1  single clock for all sequential logic.
REQ-004 UART_RX_RST  input  1  reset; synchronous and active-high, sampled on the rising edge of UART_RX_CLK.
REQ-005 RX_IN  input  1  serial line; idles high.
REQ-006 PAR_EN  input  1  1 = a parity bit follows the data bits.
REQ-007 PAR_TYP  input  1  0 = even parity (parity bit = XOR of data); 1 = odd parity (parity bit = XNOR of data).
REQ-008 Prescale  input  PRESCALE_WIDTH  clock cycles per bit; legal values are 8, 16 and 32.
REQ-009 P_DATA  output  DATA_WIDTH  last successfully received word.
REQ-010 data_valid  output  1  one-cycle pulse when P_DATA is updated.
REQ-011 par_err  output  1  one-cycle pulse on a parity mismatch.
REQ-012 stop_err  output  1  one-cycle pulse when the stop bit is sampled low.

Function
REQ-013 Frame format: start bit (0), DATA_WIDTH data bits LSB first, an optional parity bit, and one stop bit (1).
REQ-014 States: IDLE, START, DATA, PARITY, STOP.
REQ-015 Each bit spans Prescale cycles, counted by edge_cnt = 0..Prescale-1.
REQ-016 The IDLE cycle in which RX_IN=0 is observed is tick 0 of the start bit; the next state is START with edge_cnt=1.
REQ-017 Bit value = 2-of-3 majority of RX_IN sampled at ticks Prescale/2-1, Prescale/2 and Prescale/2+1.
REQ-018 START: at tick Prescale-1, a majority of 1 is a glitch and the next state is IDLE with no output pulse; otherwise the next state is DATA.
REQ-019 DATA: a bit counter advances at each tick Prescale-1; after bit DATA_WIDTH-1 the next state is PARITY if PAR_EN=1, else STOP.
REQ-020 PARITY: the sampled bit is compared with the parity computed over the shifted data using PAR_TYP; the result is held until STOP.
REQ-021 STOP: at tick Prescale/2+1 the stop bit is resolved and the state returns to IDLE in the next cycle, so a back-to-back start edge during the remaining half bit is accepted.
REQ-022 The output cycle is the cycle after the STOP decision.
REQ-023 If the stop bit is 1 and parity is OK (or disabled): P_DATA is loaded and data_valid=1 for one cycle.
REQ-024 On a parity error: par_err=1 and data_valid=0; P_DATA is unchanged.
REQ-025 If the stop bit is 0: stop_err=1 and data_valid=0; P_DATA is unchanged.
REQ-026 Parity error and stop error in the same frame: both par_err and stop_err pulse in the same cycle.
REQ-027 PAR_EN, PAR_TYP and Prescale are captured in the START tick-0 cycle and held for the whole frame; changes mid-frame take effect on the next frame.
REQ-028 A captured Prescale value other than 8, 16 or 32 is treated as 8.
REQ-029 RX_IN is double-flop synchronised before use; the idle-low detect uses the synchronised value, and all tick numbering refers to the synchronised signal.
REQ-030 data_valid, par_err and stop_err are never asserted for more than one consecutive cycle per frame.

Reset
REQ-031 While UART_RX_RST=1: state=IDLE; edge_cnt=0; bit counter=0; shift register=0; P_DATA=0; data_valid=0; par_err=0; stop_err=0; synchroniser flops=1.
REQ-032 Reset asserted mid-frame aborts the frame with no output pulse; reception resumes with the first low RX_IN after reset deasserts.

Structure
REQ-033 The state encoding, the DATA_WIDTH default and the legal prescale constants (8, 16, 32) live in the shared uart package used with the transmitter.
REQ-034 One sub-module, uart_rx_sampler, contains the edge counter and the 3-sample majority voter, and exposes bit_value and bit_done to the FSM.

Verification
REQ-035 Prescale=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity bit 0 -> data_valid pulse, P_DATA=0xA5, par_err=0, stop_err=0.
REQ-036 Prescale=16, PAR_EN=1, PAR_TYP=1, frame 0x3C with parity bit 0 (correct bit is 1) -> par_err pulse, data_valid=0, P_DATA holds its previous value.
REQ-037 Prescale=8, RX_IN low for 2 cycles then high -> FSM returns to IDLE after the START bit with no pulses; a following valid 0x5A frame -> P_DATA=0x5A.
REQ-038 Prescale=32, PAR_EN=0, frame 0x81 with stop bit 0 -> stop_err pulse, data_valid=0.
REQ-039 Prescale=8, PAR_EN=0, back-to-back frames 0x00 then 0xFF with no idle gap -> two data_valid pulses, 0x00 then 0xFF.
REQ-040 UART_RX_RST asserted at data bit 3 of frame 0x55 -> no pulses; all outputs are 0 one cycle after reset is asserted; the next frame 0x66 -> P_DATA=0x66.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the transmitter.
// Holds the frame FSM encoding, default word size and legal prescales.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int UART_DATA_WIDTH = 8;

    localparam int unsigned UART_PRESCALE_8  = 8;
    localparam int unsigned UART_PRESCALE_16 = 16;
    localparam int unsigned UART_PRESCALE_32 = 32;

    function automatic logic prescale_legal(input logic [31:0] p);
        return (p == UART_PRESCALE_8)
            || (p == UART_PRESCALE_16)
            || (p == UART_PRESCALE_32);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 3-sample majority voter for the UART receiver.
// bit_done marks the last tick of a bit; stop_tick marks the last vote sample.
module uart_rx_sampler #(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cnt_en,
    input  logic [PRESCALE_WIDTH-1:0] ps,
    input  logic                      rx,
    output logic                      bit_value,
    output logic                      bit_done,
    output logic                      stop_tick
);

    logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic                      s_lo_q, s_lo_d;
    logic                      s_mid_q, s_mid_d;
    logic                      s_hi_q, s_hi_d;
    logic [PRESCALE_WIDTH-1:0] half, t_lo, t_hi, t_end;
    logic                      s_hi;

    // Tick positions, counter advance and vote samples.
    always_comb begin
        half       = ps >> 1;
        t_lo       = half - PRESCALE_WIDTH'(1);
        t_hi       = half + PRESCALE_WIDTH'(1);
        t_end      = ps - PRESCALE_WIDTH'(1);
        edge_cnt_d = '0;
        if (cnt_en) begin
            edge_cnt_d = (edge_cnt_q == t_end) ? '0
                       : edge_cnt_q + PRESCALE_WIDTH'(1);
        end
        s_lo_d     = (edge_cnt_q == t_lo) ? rx : s_lo_q;
        s_mid_d    = (edge_cnt_q == half) ? rx : s_mid_q;
        s_hi_d     = (edge_cnt_q == t_hi) ? rx : s_hi_q;
        // The third sample is taken live so the stop bit resolves on its tick.
        s_hi       = (edge_cnt_q == t_hi) ? rx : s_hi_q;
        bit_value  = (s_lo_q & s_mid_q) | (s_lo_q & s_hi) | (s_mid_q & s_hi);
        bit_done   = (edge_cnt_q == t_end);
        stop_tick  = (edge_cnt_q == t_hi);
    end

    // Counter and sample registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt_q <= '0;
            s_lo_q     <= 1'b1;
            s_mid_q    <= 1'b1;
            s_hi_q     <= 1'b1;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            s_lo_q     <= s_lo_d;
            s_mid_q    <= s_mid_d;
            s_hi_q     <= s_hi_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchroniser, frame FSM, parity/stop checking and output.
// Frame settings are latched at the start edge and held for the frame.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = UART_DATA_WIDTH,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      UART_RX_CLK,
    input  logic                      UART_RX_RST,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      data_valid,
    output logic                      par_err,
    output logic                      stop_err
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    rx_state_e                 state_q, state_d;
    logic [1:0]                sync_q, sync_d;
    logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]     shift_q, shift_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic [PRESCALE_WIDTH-1:0] ps_q, ps_d;
    logic                      par_en_q, par_en_d;
    logic                      par_typ_q, par_typ_d;
    logic                      par_bad_q, par_bad_d;
    logic                      valid_q, valid_d;
    logic                      perr_q, perr_d;
    logic                      serr_q, serr_d;
    logic [PRESCALE_WIDTH-1:0] ps_in;
    logic                      rx_s;
    logic                      cnt_en;
    logic                      bit_value, bit_done, stop_tick;

    assign rx_s       = sync_q[1];
    assign P_DATA     = data_q;
    assign data_valid = valid_q;
    assign par_err    = perr_q;
    assign stop_err   = serr_q;

    uart_rx_sampler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_sampler (
        .clk       (UART_RX_CLK),
        .rst       (UART_RX_RST),
        .cnt_en    (cnt_en),
        .ps        (ps_q),
        .rx        (rx_s),
        .bit_value (bit_value),
        .bit_done  (bit_done),
        .stop_tick (stop_tick)
    );

    // Next-state, data path and one-cycle result pulses.
    always_comb begin
        sync_d    = {sync_q[0], RX_IN};
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        ps_d      = ps_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        par_bad_d = par_bad_q;
        valid_d   = 1'b0;
        perr_d    = 1'b0;
        serr_d    = 1'b0;
        ps_in     = prescale_legal(32'(Prescale)) ? Prescale
                  : PRESCALE_WIDTH'(UART_PRESCALE_8);
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d   = START;
                    ps_d      = ps_in;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    par_bad_d = 1'b0;
                    bit_cnt_d = '0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d   = bit_value ? IDLE : DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_d = {bit_value, shift_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        state_d   = par_en_q ? PARITY : STOP;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    par_bad_d = bit_value != ((^shift_q) ^ par_typ_q);
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (stop_tick) begin
                    state_d = IDLE;
                    serr_d  = !bit_value;
                    perr_d  = par_bad_q;
                    valid_d = bit_value && !par_bad_q;
                    if (bit_value && !par_bad_q) begin
                        data_d = shift_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        cnt_en = (state_d != IDLE);
    end

    // State and data registers.
    always_ff @(posedge UART_RX_CLK) begin
        if (UART_RX_RST) begin
            state_q   <= IDLE;
            sync_q    <= 2'b11;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            ps_q      <= PRESCALE_WIDTH'(UART_PRESCALE_8);
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            par_bad_q <= 1'b0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            serr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            ps_q      <= ps_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            par_bad_q <= par_bad_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            serr_q    <= serr_d;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven bit by bit, pulses counted
// on the falling edge and compared with hand-computed results.
module tb_uart_rx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic [5:0] prescale = 6'd8;
    logic [7:0] p_data;
    logic       data_valid, par_err, stop_err;

    int         n_chk = 0;
    int         n_err = 0;
    int         nval, nperr, nserr, nboth;
    int         ndbl = 0;
    logic [7:0] vals [4];
    logic       pv = 1'b0, pp = 1'b0, ps = 1'b0;

    uart_rx dut (
        .UART_RX_CLK (clk),
        .UART_RX_RST (rst),
        .RX_IN       (rx_in),
        .PAR_EN      (par_en),
        .PAR_TYP     (par_typ),
        .Prescale    (prescale),
        .P_DATA      (p_data),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stop_err    (stop_err)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (data_valid) begin
            if (nval < 4) vals[nval] = p_data;
            nval++;
        end
        if (par_err) nperr++;
        if (stop_err) nserr++;
        if (par_err && stop_err) nboth++;
        if ((data_valid && pv) || (par_err && pp) || (stop_err && ps)) ndbl++;
        pv = data_valid;
        pp = par_err;
        ps = stop_err;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        nval = 0;
        nperr = 0;
        nserr = 0;
        nboth = 0;
    endtask

    task automatic send_bit(input logic b, input int n);
        rx_in = b;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        send_bit(1'b1, n);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pe,
                              input bit pb, input bit sb, input int n);
        send_bit(1'b0, n);
        for (int i = 0; i < 8; i++) send_bit(d[i], n);
        if (pe) send_bit(pb, n);
        send_bit(sb, n);
        rx_in = 1'b1;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_pdata", 32'(p_data), 32'h0);
        check("rst_valid", 32'(data_valid), 32'h0);
        check("rst_perr", 32'(par_err), 32'h0);
        check("rst_serr", 32'(stop_err), 32'h0);
        rst = 1'b0;
        idle(10);

        // 0xA5, even parity, correct parity bit 0
        prescale = 6'd8; par_en = 1'b1; par_typ = 1'b0;
        clr();
        send_frame(8'hA5, 1, 1'b0, 1'b1, 8);
        idle(16);
        check("a5_valid", 32'(nval), 32'd1);
        check("a5_pdata", 32'(p_data), 32'hA5);
        check("a5_perr", 32'(nperr), 32'd0);
        check("a5_serr", 32'(nserr), 32'd0);

        // 0x3C, odd parity, wrong parity bit 0
        prescale = 6'd16; par_en = 1'b1; par_typ = 1'b1;
        clr();
        send_frame(8'h3C, 1, 1'b0, 1'b1, 16);
        idle(32);
        check("3c_perr", 32'(nperr), 32'd1);
        check("3c_valid", 32'(nval), 32'd0);
        check("3c_pdata", 32'(p_data), 32'hA5);
        check("3c_serr", 32'(nserr), 32'd0);

        // short start glitch, then a clean 0x5A
        prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
        clr();
        send_bit(1'b0, 2);
        idle(20);
        check("glitch_pulses", 32'(nval + nperr + nserr), 32'd0);
        check("glitch_idle", 32'(dut.state_q), 32'(IDLE));
        send_frame(8'h5A, 0, 1'b0, 1'b1, 8);
        idle(16);
        check("5a_valid", 32'(nval), 32'd1);
        check("5a_pdata", 32'(p_data), 32'h5A);

        // 0x81 at prescale 32 with a low stop bit
        prescale = 6'd32;
        clr();
        send_frame(8'h81, 0, 1'b0, 1'b0, 32);
        idle(64);
        check("81_serr", 32'(nserr), 32'd1);
        check("81_valid", 32'(nval), 32'd0);
        check("81_perr", 32'(nperr), 32'd0);
        check("81_pdata", 32'(p_data), 32'h5A);

        // back-to-back frames, no idle gap
        prescale = 6'd8;
        clr();
        send_frame(8'h00, 0, 1'b0, 1'b1, 8);
        send_frame(8'hFF, 0, 1'b0, 1'b1, 8);
        idle(16);
        check("b2b_count", 32'(nval), 32'd2);
        check("b2b_first", 32'(vals[0]), 32'h00);
        check("b2b_second", 32'(vals[1]), 32'hFF);

        // illegal prescale 12 behaves as 8
        prescale = 6'd12;
        clr();
        send_frame(8'hC3, 0, 1'b0, 1'b1, 8);
        idle(16);
        check("ps12_valid", 32'(nval), 32'd1);
        check("ps12_pdata", 32'(p_data), 32'hC3);

        // parity and stop error together: 0x01 needs even parity 1
        prescale = 6'd8; par_en = 1'b1; par_typ = 1'b0;
        clr();
        send_frame(8'h01, 1, 1'b0, 1'b0, 8);
        idle(16);
        check("both_same_cycle", 32'(nboth), 32'd1);
        check("both_valid", 32'(nval), 32'd0);
        check("both_pdata", 32'(p_data), 32'hC3);

        // reset during data bit 3 of 0x55
        par_en = 1'b0;
        clr();
        send_bit(1'b0, 8);
        send_bit(1'b1, 8);
        send_bit(1'b0, 8);
        send_bit(1'b1, 8);
        send_bit(1'b0, 4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_pdata", 32'(p_data), 32'h0);
        check("mrst_valid", 32'(data_valid), 32'h0);
        check("mrst_perr", 32'(par_err), 32'h0);
        check("mrst_serr", 32'(stop_err), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(40);
        check("mrst_pulses", 32'(nval + nperr + nserr), 32'd0);
        send_frame(8'h66, 0, 1'b0, 1'b1, 8);
        idle(16);
        check("66_valid", 32'(nval), 32'd1);
        check("66_pdata", 32'(p_data), 32'h66);

        check("single_cycle_pulses", 32'(ndbl), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
